// File: rtl/mem_cmd_scheduler.sv
// mem_cmd_scheduler: round-robin write/read command scheduler onto one Avalon-MM master with read-credit limiting
// clk_i, rst_n_i                     : clock, asynchronous active-low reset
// wr_valid_i/wr_addr_i/wr_data_i     : write command offer; wr_ready_o accepts it
// rd_valid_i/rd_addr_i               : read command offer; rd_ready_o accepts it
// avm_*                              : Avalon-MM master, driven straight from the command register
// rd_data_o/rd_data_valid_o          : read beats delayed by one cycle
// outstanding_o, idle_o, unexp_rdv_o : read credits, idle status, sticky unexpected-readdatavalid flag
module mem_cmd_scheduler #(
   parameter int ADDR_W = 31,
   parameter int DATA_W = 128,
   parameter int MAX_OUTSTANDING = 8,
   localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              wr_valid_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   output logic              wr_ready_o,
   input  logic              rd_valid_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic              rd_ready_o,
   output logic [ADDR_W-1:0] avm_address_o,
   output logic              avm_write_o,
   output logic              avm_read_o,
   output logic [DATA_W-1:0] avm_writedata_o,
   input  logic              avm_waitrequest_i,
   input  logic              avm_readdatavalid_i,
   input  logic [DATA_W-1:0] avm_readdata_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              rd_data_valid_o,
   output logic [CW-1:0]     outstanding_o,
   output logic              idle_o,
   output logic              unexp_rdv_o
);
   typedef enum logic {WR = 1'b0, RD = 1'b1} cmd_e;
   localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);
   cmd_e              type_q, last_q;
   logic              cmd_vld_q, rdv_q, unexp_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q, rdata_q;
   logic [CW-1:0]     cred_q, cred_d;
   logic              slot_free, rd_elig, gnt_wr, gnt_rd, dec;
   // a write wins unless a read is also eligible and the last grant was a write
   always_comb begin
      slot_free = !cmd_vld_q | !avm_waitrequest_i;
      rd_elig   = slot_free & (cred_q < MAX_C);
      gnt_wr    = wr_valid_i & slot_free & (!(rd_valid_i & rd_elig) | (last_q == RD));
      gnt_rd    = rd_valid_i & rd_elig & !gnt_wr;
      dec       = avm_readdatavalid_i & (cred_q != '0);
      cred_d    = cred_q + CW'(gnt_rd) - CW'(dec);
   end
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cmd_vld_q <= 1'b0;
         type_q    <= WR;
         last_q    <= RD;
         addr_q    <= '0;
         data_q    <= '0;
         cred_q    <= '0;
         unexp_q   <= 1'b0;
         rdv_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         if (gnt_wr | gnt_rd) begin
            cmd_vld_q <= 1'b1;
            type_q    <= gnt_rd ? RD : WR;
            last_q    <= gnt_rd ? RD : WR;
            addr_q    <= gnt_rd ? rd_addr_i : wr_addr_i;
         end else if (!avm_waitrequest_i) begin
            cmd_vld_q <= 1'b0;
         end
         if (gnt_wr) data_q <= wr_data_i;
         cred_q  <= cred_d;
         unexp_q <= unexp_q | (avm_readdatavalid_i & (cred_q == '0));
         rdv_q   <= avm_readdatavalid_i;
         rdata_q <= avm_readdata_i;
      end
   end
   assign wr_ready_o      = gnt_wr;
   assign rd_ready_o      = gnt_rd;
   assign avm_address_o   = addr_q;
   assign avm_writedata_o = data_q;
   assign avm_write_o     = cmd_vld_q & (type_q == WR);
   assign avm_read_o      = cmd_vld_q & (type_q == RD);
   assign rd_data_o       = rdata_q;
   assign rd_data_valid_o = rdv_q;
   assign outstanding_o   = cred_q;
   assign idle_o          = !cmd_vld_q & (cred_q == '0);
   assign unexp_rdv_o     = unexp_q;
endmodule

// File: tb/tb_mem_cmd_scheduler.sv
// tb_mem_cmd_scheduler: directed bench with a transaction-level model checked every cycle
module tb_mem_cmd_scheduler;
   localparam int AW = 16, DW = 32, MAXO = 2;
   logic clk = 0, rst_n = 0;
   logic wv = 0, rv = 0, wt = 0, rdv = 0;
   logic [AW-1:0] wa = 0, ra = 0;
   logic [DW-1:0] wd = 0, rdata = 0;
   logic wr_ready, rd_ready, avm_write, avm_read, rd_dv, idle, unexp;
   logic [AW-1:0] avm_addr;
   logic [DW-1:0] avm_wdata, rd_d;
   logic [1:0] outst;
   int tests = 0, fails = 0, cnt10 = 0;
   logic [AW-1:0] wlog[$], rlog[$];
   int glog[$];
   bit m_vld, m_rd, m_last, m_unexp, m_rdv;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data, m_rdata;
   int m_cred;
   always #5 clk = ~clk;
   mem_cmd_scheduler #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .wr_valid_i(wv), .wr_addr_i(wa), .wr_data_i(wd), .wr_ready_o(wr_ready),
      .rd_valid_i(rv), .rd_addr_i(ra), .rd_ready_o(rd_ready),
      .avm_address_o(avm_addr), .avm_write_o(avm_write), .avm_read_o(avm_read),
      .avm_writedata_o(avm_wdata), .avm_waitrequest_i(wt),
      .avm_readdatavalid_i(rdv), .avm_readdata_i(rdata),
      .rd_data_o(rd_d), .rd_data_valid_o(rd_dv), .outstanding_o(outst),
      .idle_o(idle), .unexp_rdv_o(unexp)
   );
   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   // model: one held command, a credit counter and the last grant, stepped once per cycle
   always @(negedge clk) begin
      bit free, re, gw, gr;
      if (!rst_n) begin
         m_vld = 0; m_rd = 0; m_addr = 0; m_data = 0; m_cred = 0;
         m_last = 1; m_unexp = 0; m_rdv = 0; m_rdata = 0;
      end
      free = !m_vld || !wt;
      re   = rv && free && (m_cred < MAXO);
      gw   = wv && free && (!re || m_last);
      gr   = re && !gw;
      chk("avm_write", avm_write, m_vld && !m_rd);
      chk("avm_read", avm_read, m_vld && m_rd);
      if (m_vld) chk("avm_address", avm_addr, m_addr);
      if (m_vld && !m_rd) chk("avm_writedata", avm_wdata, m_data);
      chk("wr_ready", wr_ready, gw);
      chk("rd_ready", rd_ready, gr);
      chk("outstanding", outst, m_cred);
      chk("idle", idle, !m_vld && m_cred == 0);
      chk("unexp", unexp, m_unexp);
      chk("rd_data_valid", rd_dv, m_rdv);
      if (m_rdv) chk("rd_data", rd_d, m_rdata);
      if (rst_n) begin
         if (wr_ready) glog.push_back(0);
         if (rd_ready) glog.push_back(1);
         if (avm_write && !wt) wlog.push_back(avm_addr);
         if (avm_read && !wt) rlog.push_back(avm_addr);
         if (avm_write && avm_addr == 16'h10) cnt10++;
         m_rdv = rdv;
         m_rdata = rdata;
         if (rdv && m_cred == 0) m_unexp = 1;
         m_cred = m_cred + int'(gr) - int'(rdv && m_cred > 0);
         if (gw || gr) begin
            m_vld = 1; m_rd = gr; m_last = gr;
            m_addr = gr ? ra : wa;
            if (gw) m_data = wd;
         end else if (!wt) m_vld = 0;
      end
   end
   initial begin
      repeat (3) tick;
      @(negedge clk);
      chk("reset_idle", idle, 1);
      chk("reset_write", avm_write, 0);
      rst_n = 1;
      tick;
      // back-to-back writes
      wlog.delete(); glog.delete();
      for (int i = 0; i < 4; i++) begin
         wv = 1; wa = 16'h100 + 16'(i); wd = 32'(i); tick;
      end
      wv = 0; tick; tick;
      chk("b2b_count", wlog.size(), 4);
      chk("b2b_grants", glog.size(), 4);
      for (int i = 0; i < 4; i++) chk("b2b_addr", wlog[i], 16'h100 + 16'(i));
      // waitrequest stall
      wlog.delete();
      wt = 1; wv = 1; wa = 16'h10; wd = 32'hAB; tick;
      wa = 16'h20; wd = 32'hCD; tick; tick; tick;
      wt = 0; tick;
      wv = 0; tick; tick;
      chk("stall_cycles", cnt10, 4);
      chk("stall_count", wlog.size(), 2);
      chk("stall_first", wlog[0], 16'h10);
      chk("stall_second", wlog[1], 16'h20);
      // credit limit
      rlog.delete();
      rv = 1; ra = 16'h200; tick;
      ra = 16'h201; tick;
      ra = 16'h202; tick; tick;
      @(negedge clk);
      chk("limit_outst", outst, 2);
      chk("limit_block", rd_ready, 0);
      tick;
      rdv = 1; rdata = 32'h55; tick;
      rdv = 0;
      @(negedge clk);
      chk("limit_release", rd_ready, 1);
      chk("limit_rdv", rd_dv, 1);
      chk("limit_rdata", rd_d, 32'h55);
      tick;
      rv = 0; tick; tick;
      chk("limit_reads", rlog.size(), 3);
      for (int i = 0; i < 3; i++) chk("limit_addr", rlog[i], 16'h200 + 16'(i));
      // simultaneous credit update at credits=1
      rdv = 1; rdata = 32'h66; tick;
      rdv = 0; rv = 1; ra = 16'h300; rdv = 1; rdata = 32'h77; tick;
      rv = 0; rdv = 0;
      @(negedge clk);
      chk("simul_outst", outst, 1);
      tick;
      rdv = 1; tick;
      rdv = 0; tick;
      @(negedge clk);
      chk("drain_idle", idle, 1);
      tick;
      // tie arbitration after reset
      rst_n = 0; tick; tick;
      rst_n = 1; glog.delete();
      wv = 1; rv = 1; wa = 16'h400; ra = 16'h500;
      repeat (4) tick;
      wv = 0; rv = 0; tick;
      chk("tie_count", glog.size(), 4);
      for (int i = 0; i < 4; i++) chk("tie_order", glog[i], i % 2);
      rdv = 1; tick; tick;
      rdv = 0; tick;
      // unexpected response then reset mid-stall
      rdv = 1; rdata = 32'h99; tick;
      rdv = 0; tick; tick;
      @(negedge clk);
      chk("unexp_set", unexp, 1);
      chk("unexp_outst", outst, 0);
      tick;
      wt = 1; wv = 1; wa = 16'h600; tick;
      wv = 0; tick;
      rst_n = 0; #1;
      chk("rst_write", avm_write, 0);
      chk("rst_read", avm_read, 0);
      chk("rst_idle", idle, 1);
      chk("rst_unexp", unexp, 0);
      wt = 0; tick;
      rst_n = 1; tick; tick;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mem_cmd_scheduler.md
MEM_CMD_SCHEDULER -- requirements
Module: mem_cmd_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 31, meaning the Avalon-MM word address width.
REQ-002 SHALL have parameter DATA_W, default 128, meaning the data bus width.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 8, range 1..64, meaning the read-credit limit.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port wr_valid_i, input, 1 bit: a write command is offered.
REQ-007 SHALL have port wr_addr_i / wr_data_i, input, ADDR_W / DATA_W bits: the write address and data.
REQ-008 SHALL have port wr_ready_o, output, 1 bit: the write command is taken this cycle when it is high together with wr_valid_i.
REQ-009 SHALL have port rd_valid_i / rd_addr_i, input, 1 / ADDR_W bits: a read command is offered.
REQ-010 SHALL have port rd_ready_o, output, 1 bit: the read command is taken this cycle when it is high together with rd_valid_i.
REQ-011 SHALL have Avalon-MM master ports: avm_address_o (ADDR_W), avm_write_o, avm_read_o, avm_writedata_o (DATA_W), avm_waitrequest_i, avm_readdatavalid_i, avm_readdata_i (DATA_W).
REQ-012 SHALL have port rd_data_o / rd_data_valid_o, output, DATA_W / 1 bits: read data forwarded to the checker.
REQ-013 SHALL have port outstanding_o, output, $clog2(MAX_OUTSTANDING+1) bits: the current read-credit count.
REQ-014 SHALL have port idle_o, output, 1 bit: no command is held and no reads are outstanding.
REQ-015 SHALL have port unexp_rdv_o, output, 1 bit: a sticky flag set by readdatavalid arriving with zero credits.

Function
REQ-016 SHALL hold one command register (cmd_vld_q, type, address, data) that drives the avm_* outputs directly; avm_write_o = cmd_vld_q & type==WR; avm_read_o = cmd_vld_q & type==RD.
REQ-017 SHALL compute slot_free = !cmd_vld_q | !avm_waitrequest_i; this value is combinational from waitrequest.
REQ-018 SHALL set rd_elig = slot_free & (credits < MAX_OUTSTANDING) and wr_elig = slot_free.
REQ-019 SHALL arbitrate round-robin when both valids are high and both are eligible: grant the type opposite to last_grant_q; after reset last_grant_q = RD, so WR wins the first tie.
REQ-020 SHALL, when only one requester is valid and eligible, grant it regardless of last_grant_q.
REQ-021 SHALL drive wr_ready_o / rd_ready_o high only for the granted type; at most one ready is high per cycle.
REQ-022 SHALL, on a transfer, load the command register next edge and set cmd_vld_q = 1; last_grant_q takes the granted type.
REQ-023 SHALL, when the register drains (cmd_vld_q & !waitrequest) with no new transfer, clear cmd_vld_q next edge.
REQ-024 SHALL support back-to-back issue: one command per cycle when waitrequest stays low.
REQ-025 SHALL hold address, data and type stable while cmd_vld_q & avm_waitrequest_i (Avalon hold rule).
REQ-026 SHALL update credits as follows: +1 on a read transfer into the register; -1 on avm_readdatavalid_i when credits>0; unchanged when both occur in the same cycle; never exceed MAX_OUTSTANDING or wrap below 0.
REQ-027 SHALL, on readdatavalid with credits==0, set unexp_rdv_o (sticky until reset) and leave credits at 0.
REQ-028 SHALL register rd_data_o / rd_data_valid_o one cycle after avm_readdata_i / avm_readdatavalid_i, including an unexpected beat.
REQ-029 SHALL compute idle_o = !cmd_vld_q & credits==0, driven from registers.
REQ-030 SHALL block further reads when credits == MAX_OUTSTANDING while writes continue to be granted.

Reset
REQ-031 SHALL, while rst_n_i is low, asynchronously clear cmd_vld_q, credits, unexp_rdv_o, rd_data_valid_o, avm_read_o and avm_write_o, set last_grant_q = RD, and clear the address and data registers to 0.
REQ-032 SHALL treat an in-flight command or read response interrupted by reset as lost, with no replay; idle_o = 1 after reset.

Verification
REQ-033 Back-to-back writes: wr_valid held for 4 cycles, waitrequest=0 -> 4 consecutive avm_write_o cycles, addresses in order, wr_ready_o high on each.
REQ-034 Waitrequest stall: write at addr 0x10 with waitrequest=1 for 3 cycles -> address and data held constant, wr_ready_o=0 during the stall, write retires on cycle 4.
REQ-035 Credit limit: MAX_OUTSTANDING=2, 3 reads, no readdatavalid -> 2 reads issued, rd_ready_o=0, outstanding_o=2; one readdatavalid -> the third read issues next cycle.
REQ-036 Tie arbitration after reset: wr_valid and rd_valid both held -> grants alternate WR, RD, WR, RD.
REQ-037 Simultaneous credit update: a read transfer and a readdatavalid in the same cycle at credits=1 -> credits stays 1.
REQ-038 Unexpected response and reset: readdatavalid at credits=0 -> unexp_rdv_o=1 and stays 1; rst_n_i low mid-stall -> all avm_* outputs low, idle_o=1, unexp_rdv_o=0.
